// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority vote, false-start reject and break detect
module uart_rx_os #(
  parameter int clk_freq    = 3_686_400,
  parameter int baud_rate   = 115_200,
  parameter int data_bits   = 8,
  parameter int parity_type = 0,
  parameter int stop_bits   = 1,
  parameter int oversample  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [data_bits-1:0] rx_data_out,
  output logic                 rx_data_vld,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_active
);
  localparam int div   = clk_freq / (baud_rate * oversample);
  localparam int div_w = div > 2 ? $clog2(div) : 1;
  localparam int sw    = $clog2(oversample);
  if (div < 2) begin : g_bad_div
    $error("uart_rx_os: clk_freq/(baud_rate*oversample) must be >= 2");
  end
  if (data_bits < 5 || data_bits > 9 || parity_type > 2 || stop_bits < 1 || stop_bits > 2
      || oversample < 8 || oversample % 2 != 0) begin : g_bad_cfg
    $error("uart_rx_os: unsupported frame configuration");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t r_state, w_next;
  logic r_sync1, r_sync2, r_prev;
  logic [2:0] r_warm;
  logic [div_w-1:0] r_div;
  logic [sw-1:0] r_smp;
  logic [3:0] r_bit;
  logic r_s0, r_s1, r_any1, r_perr, r_ferr, r_hi;
  logic [data_bits-1:0] r_shift;
  logic w_fall, w_start, w_tick, w_bit_end, w_vote_evt, w_vote, w_done, w_zero;
  // r_warm only lets an edge count once r_prev holds a real post-reset sample of the line
  assign w_fall     = r_warm[2] & r_prev & ~r_sync2;
  assign w_start    = (r_state == IDLE) & w_fall;
  assign w_tick     = r_div == div_w'(div - 1);
  assign w_bit_end  = w_tick & (r_smp == sw'(oversample - 1));
  assign w_vote_evt = w_tick & (r_smp == sw'(oversample / 2 + 1));
  assign w_vote     = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
  assign w_done     = (r_state == STOP) & w_vote_evt & (r_bit == 4'(stop_bits - 1));
  assign w_zero     = ~(r_any1 | w_vote);
  assign rx_active  = r_state != IDLE;
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // frame sequencing: bit ends advance the frame, the last stop vote ends it early
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fall ? START : IDLE;
      START:   w_next = (w_vote_evt & w_vote) ? IDLE : w_bit_end ? DATA : START;
      DATA:    w_next = (w_bit_end & (r_bit == 4'(data_bits - 1))) ? (parity_type != 0 ? PARITY : STOP) : DATA;
      PARITY:  w_next = w_bit_end ? STOP : PARITY;
      STOP:    w_next = w_done ? (w_zero ? BRK : IDLE) : STOP;
      BRK:     w_next = (w_tick & r_hi & r_sync2) ? IDLE : BRK;
      default: w_next = IDLE;
    endcase
  end
  // synchroniser, tick/sample timing, bit voting, deframing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_prev        <= 1'b1;
      r_warm        <= '0;
      r_div         <= '0;
      r_smp         <= '0;
      r_bit         <= '0;
      r_s0          <= 1'b1;
      r_s1          <= 1'b1;
      r_any1        <= 1'b0;
      r_perr        <= 1'b0;
      r_ferr        <= 1'b0;
      r_hi          <= 1'b0;
      r_shift       <= '0;
      rx_data_out   <= '0;
      rx_data_vld   <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      r_sync1       <= rx;
      r_sync2       <= r_sync1;
      r_prev        <= r_sync2;
      r_warm        <= {r_warm[1:0], 1'b1};
      r_div         <= (w_start | w_tick) ? '0 : r_div + div_w'(1);
      r_smp         <= w_start ? '0 : w_tick ? (w_bit_end ? '0 : r_smp + sw'(1)) : r_smp;
      r_bit         <= w_start ? '0 : (w_bit_end & (r_state != IDLE)) ? (w_next != r_state ? '0 : r_bit + 4'd1) : r_bit;
      if (w_tick && r_smp == sw'(oversample / 2 - 1)) r_s0 <= r_sync2;
      if (w_tick && r_smp == sw'(oversample / 2)) r_s1 <= r_sync2;
      if (r_state == DATA && w_vote_evt) r_shift <= {w_vote, r_shift[data_bits-1:1]};
      r_any1        <= w_start ? 1'b0 : r_any1 | (w_vote_evt & w_vote);
      r_perr        <= w_start ? 1'b0 : (r_state == PARITY && w_vote_evt) ? ((^r_shift ^ w_vote) ^ (parity_type == 1)) : r_perr;
      r_ferr        <= w_start ? 1'b0 : r_ferr | ((r_state == STOP) & w_vote_evt & ~w_vote);
      r_hi          <= (r_state == BRK) & r_sync2 & (r_hi | w_tick);
      rx_data_vld   <= w_done;
      rx_parity_err <= w_done & r_perr;
      rx_frame_err  <= w_done & (r_ferr | ~w_vote);
      rx_break      <= w_done & w_zero;
      if (w_done) rx_data_out <= r_shift;
    end
  end
endmodule
